// File: rtl/uart_rx.sv
// uart_rx: receive side of the 8-bit UART link.
// Frame: start(0), 8 data bits LSB first, even parity, stop(1).
// The serial input is synchronised, the start bit is confirmed at mid-bit,
// each bit is sampled once, and the finished byte is held behind valid/ack.
//
// Handshake: rx_valid rises when a frame completes and stays high until the
// consumer pulses rx_ack. An rx_ack cycle with no completion drops rx_valid
// and rx_overrun. A completion while rx_valid=1 and rx_ack=0 overwrites the
// byte and sets the sticky rx_overrun. A completion in the same cycle as
// rx_ack counts as a fresh byte: rx_valid stays 1 and rx_overrun is 0.
// rx_ack is ignored while rx_valid=0.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial_in,
  input  logic       rx_ack,
  output logic [7:0] rx_data_out,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shreg;
  logic                   parity_bit;
  logic                   tick;
  logic                   done;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign tick = (cnt == LAST);
  assign done = (state == STOP) && tick;

  // Synchroniser for the asynchronous serial line; resets to the idle level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial_in};
    end
  end

  // Frame FSM with registered outputs and the valid/ack/overrun handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rx_busy       <= 1'b0;
      cnt           <= '0;
      bit_idx       <= 3'd0;
      shreg         <= 8'h00;
      parity_bit    <= 1'b0;
      rx_data_out   <= 8'h00;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            if (HALF == '0) begin
              // Start bit is already at its sample point: go straight to data.
              state   <= DATA;
              cnt     <= '0;
              bit_idx <= 3'd0;
            end else begin
              state <= START;
              cnt   <= CW'(1);
            end
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF) begin
            if (!rx_s) begin
              state   <= DATA;
              cnt     <= '0;
              bit_idx <= 3'd0;
            end else begin
              // Line went high again before mid-bit: treat as a glitch.
              state   <= IDLE;
              cnt     <= '0;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (tick) begin
            shreg[bit_idx] <= rx_s;
            cnt            <= '0;
            if (bit_idx == 3'd7) begin
              state <= PARITY;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PARITY: begin
          if (tick) begin
            parity_bit <= rx_s;
            cnt        <= '0;
            state      <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (tick) begin
            cnt     <= '0;
            state   <= IDLE;
            rx_busy <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          rx_busy <= 1'b0;
        end
      endcase

      if (done) begin
        rx_data_out   <= shreg;
        rx_parity_err <= (^shreg) != parity_bit;
        rx_frame_err  <= ~rx_s;
        rx_valid      <= 1'b1;
        if (rx_valid && !rx_ack) begin
          rx_overrun <= 1'b1;
        end else if (rx_ack) begin
          rx_overrun <= 1'b0;
        end
      end else if (rx_ack) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx, one instance at one clk per bit
// and one at 16 clks per bit. Table-driven frames plus hand-written
// sequences for latency, overrun, ack-at-completion, glitch and reset.
module tb_uart_rx;

  logic clk = 1'b0;
  logic reset;

  // Clock and reset
  always #5 clk = ~clk;

  logic       rx1, ack1;
  logic [7:0] data1;
  logic       valid1, perr1, ferr1, ovr1, busy1;

  logic       rx16, ack16;
  logic [7:0] data16;
  logic       valid16, perr16, ferr16, ovr16, busy16;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .reset(reset), .rx_serial_in(rx1), .rx_ack(ack1),
    .rx_data_out(data1), .rx_valid(valid1), .rx_parity_err(perr1),
    .rx_frame_err(ferr1), .rx_overrun(ovr1), .rx_busy(busy1)
  );

  uart_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .reset(reset), .rx_serial_in(rx16), .rx_ack(ack16),
    .rx_data_out(data16), .rx_valid(valid16), .rx_parity_err(perr16),
    .rx_frame_err(ferr16), .rx_overrun(ovr16), .rx_busy(busy16)
  );

  typedef struct {
    logic [7:0] data;
    logic       parity;
    logic       stop;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge.
  task automatic bit1(input logic b);
    @(negedge clk);
    rx1 = b;
  endtask

  task automatic send1(input logic [7:0] d, input logic p, input logic s);
    bit1(1'b0);
    for (int i = 0; i < 8; i++) bit1(d[i]);
    bit1(p);
    bit1(s);
  endtask

  task automatic idle1(input int n);
    repeat (n) bit1(1'b1);
  endtask

  task automatic ack_pulse1();
    @(negedge clk);
    ack1 = 1'b1;
    @(negedge clk);
    ack1 = 1'b0;
  endtask

  task automatic bit16(input logic b);
    @(negedge clk);
    rx16 = b;
    repeat (15) @(negedge clk);
  endtask

  task automatic send16(input logic [7:0] d, input logic p, input logic s);
    bit16(1'b0);
    for (int i = 0; i < 8; i++) bit16(d[i]);
    bit16(p);
    bit16(s);
  endtask

  task automatic chk_all1(input string name, input logic [7:0] d, input logic v,
                          input logic pe, input logic fe, input logic ov);
    chk({name, " data"}, data1, d);
    chk({name, " valid"}, {7'd0, valid1}, {7'd0, v});
    chk({name, " parity_err"}, {7'd0, perr1}, {7'd0, pe});
    chk({name, " frame_err"}, {7'd0, ferr1}, {7'd0, fe});
    chk({name, " overrun"}, {7'd0, ovr1}, {7'd0, ov});
  endtask

  initial begin
    logic [7:0] exp_d;
    logic       saw_busy;
    int         waited;

    // Frame table: parity is even over the data byte.
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h7E, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};

    reset = 1'b1; rx1 = 1'b1; ack1 = 1'b0; rx16 = 1'b1; ack16 = 1'b0;
    repeat (3) @(negedge clk);
    chk_all1("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset busy", {7'd0, busy1}, 8'h00);
    chk("reset data16", data16, 8'h00);
    chk("reset valid16", {7'd0, valid16}, 8'h00);
    reset = 1'b0;
    idle1(3);

    // Latency: stop bit enters the input flop on the first edge after it is
    // driven, rx_valid follows two edges later.
    send1(8'hA5, 1'b0, 1'b1);
    idle1(1);
    @(negedge clk);
    chk("latency early valid", {7'd0, valid1}, 8'h00);
    @(negedge clk);
    chk_all1("latency A5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    ack_pulse1();
    @(negedge clk);
    chk("ack clears valid", {7'd0, valid1}, 8'h00);

    // Table of frames, each acknowledged before the next.
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(vecs[k].data);
      send1(vecs[k].data, vecs[k].parity, vecs[k].stop);
      idle1(4);
      exp_d = exp_q.pop_front();
      chk_all1($sformatf("vec%0d", k), exp_d, 1'b1, vecs[k].exp_perr, vecs[k].exp_ferr, 1'b0);
      chk($sformatf("vec%0d busy", k), {7'd0, busy1}, 8'h00);
      ack_pulse1();
      @(negedge clk);
      chk($sformatf("vec%0d acked valid", k), {7'd0, valid1}, 8'h00);
      chk($sformatf("vec%0d perr kept", k), {7'd0, perr1}, {7'd0, vecs[k].exp_perr});
      chk($sformatf("vec%0d ferr kept", k), {7'd0, ferr1}, {7'd0, vecs[k].exp_ferr});
    end

    // Overrun: two frames without ack.
    send1(8'h3C, 1'b0, 1'b1);
    send1(8'hC3, 1'b0, 1'b1);
    idle1(4);
    chk_all1("overrun", 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1);
    ack_pulse1();
    @(negedge clk);
    chk("overrun ack valid", {7'd0, valid1}, 8'h00);
    chk("overrun ack flag", {7'd0, ovr1}, 8'h00);

    // Ack landing in the completion cycle: new byte kept, no overrun.
    send1(8'h3C, 1'b0, 1'b1);
    idle1(4);
    send1(8'h5A, 1'b0, 1'b1);
    idle1(1);
    @(negedge clk);
    ack1 = 1'b1;
    @(negedge clk);
    ack1 = 1'b0;
    @(negedge clk);
    chk_all1("ack at completion", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of 0xFF, after data bit 3.
    bit1(1'b0);
    repeat (4) bit1(1'b1);
    @(negedge clk);
    reset = 1'b1;
    rx1 = 1'b1;
    @(negedge clk);
    chk_all1("mid reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid reset busy", {7'd0, busy1}, 8'h00);
    reset = 1'b0;
    idle1(3);
    send1(8'h81, 1'b0, 1'b1);
    idle1(4);
    chk_all1("after reset 81", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);

    // 16 clks per bit: a 4-clk low glitch must not start a frame.
    saw_busy = 1'b0;
    @(negedge clk);
    rx16 = 1'b0;
    repeat (4) @(negedge clk);
    rx16 = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (busy16) saw_busy = 1'b1;
    end
    chk("glitch saw busy", {7'd0, saw_busy}, 8'h01);
    chk("glitch busy back", {7'd0, busy16}, 8'h00);
    chk("glitch valid", {7'd0, valid16}, 8'h00);

    send16(8'h5A, 1'b0, 1'b1);
    rx16 = 1'b1;
    waited = 0;
    while (!valid16 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("cpb16 valid", {7'd0, valid16}, 8'h01);
    chk("cpb16 data", data16, 8'h5A);
    chk("cpb16 parity_err", {7'd0, perr16}, 8'h00);
    chk("cpb16 frame_err", {7'd0, ferr16}, 8'h00);
    chk("cpb16 overrun", {7'd0, ovr16}, 8'h00);

    // Report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
